// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: in-order pipe writes win, late results queue in a FIFO.
// Optional WB_PERF_CNT_EN adds a saturating late-path stall counter output (stall_cnt).
module reg_wb_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_wa,
  input  logic [31:0] pipe_wd,
  input  logic        late_valid,
  input  logic [4:0]  late_wa,
  input  logic [31:0] late_wd,
  output logic        late_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] pending_mask,
  output logic        busy
`ifdef WB_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PtrOne = 1;

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic [4:0]        wa_q [DEPTH];
  logic [31:0]       wd_q [DEPTH];
  logic [DEPTH-1:0]  kill_q, kill_d;
  logic [DEPTH-1:0]  live;
  logic              ready_q;
  logic              full, empty;
  logic              pipe_hit, handshake, push, pop;
  logic              head_kill;
  logic              rf_wen_q, rf_wen_d;
  logic [4:0]        rf_wa_q, rf_wa_d;
  logic [31:0]       rf_wd_q, rf_wd_d;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign count  = wr_ptr_q - rd_ptr_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

  // ready_q keeps the late port closed until the first edge after reset release.
  assign late_ready = ready_q & ~full;
  assign handshake  = late_valid & late_ready;
  assign pipe_hit   = pipe_wen & (pipe_wa != 5'd0);
  assign push       = handshake & (late_wa != 5'd0);
  assign pop        = ~pipe_hit & ~empty;
  assign head_kill  = kill_q[rd_idx];

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [AW-1:0] off;
    off  = '0;
    live = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off     = AW'(i) - rd_idx;
      live[i] = ({1'b0, off} < count);
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live[i] && !kill_q[i]) begin
        pending_mask[wa_q[i]] = 1'b1;
      end
    end
  end

  assign busy = ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    kill_d   = kill_q;
    if (pipe_hit) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (live[i] && (wa_q[i] == pipe_wa)) begin
          kill_d[i] = 1'b1;
        end
      end
    end
    if (push) begin
      // A same-cycle pipe write to the same register supersedes the incoming late result.
      kill_d[wr_idx] = pipe_hit && (late_wa == pipe_wa);
      wr_ptr_d       = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  always_comb begin
    rf_wen_d = 1'b0;
    rf_wa_d  = rf_wa_q;
    rf_wd_d  = rf_wd_q;
    if (pipe_hit) begin
      rf_wen_d = 1'b1;
      rf_wa_d  = pipe_wa;
      rf_wd_d  = pipe_wd;
    end else if (pop && !head_kill) begin
      rf_wen_d = 1'b1;
      rf_wa_d  = wa_q[rd_idx];
      rf_wd_d  = wd_q[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      kill_q   <= '0;
      ready_q  <= 1'b0;
      rf_wen_q <= 1'b0;
      rf_wa_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      kill_q   <= kill_d;
      ready_q  <= 1'b1;
      rf_wen_q <= rf_wen_d;
      rf_wa_q  <= rf_wa_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  // Payload storage needs no reset; liveness comes from the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      wa_q[wr_idx] <= late_wa;
      wd_q[wr_idx] <= late_wd;
    end
  end

  assign rf_wen = rf_wen_q;
  assign rf_wa  = rf_wa_q;
  assign rf_wd  = rf_wd_q;

`ifdef WB_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (late_valid && !late_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_reg_wb_arbiter;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        pipe_wen;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic        late_valid;
  logic [4:0]  late_wa;
  logic [31:0] late_wd;
  logic        late_ready;
  logic        rf_wen;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] pending_mask;
  logic        busy;
`ifdef WB_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif

  reg_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_wen     (pipe_wen),
    .pipe_wa      (pipe_wa),
    .pipe_wd      (pipe_wd),
    .late_valid   (late_valid),
    .late_wa      (late_wa),
    .late_wd      (late_wd),
    .late_ready   (late_ready),
    .rf_wen       (rf_wen),
    .rf_wa        (rf_wa),
    .rf_wd        (rf_wd),
    .pending_mask (pending_mask),
    .busy         (busy)
`ifdef WB_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of accepted late results with a superseded flag.
  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          killed;
  } entry_t;

  entry_t      mq[$];
  bit          m_ready;
  logic        m_wen;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          m_stall;
  logic        s_ready;

  function automatic void model_reset();
    mq.delete();
    m_ready = 0;
    m_wen   = 1'b0;
    m_wa    = '0;
    m_wd    = '0;
    m_stall = 0;
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) if (!mq[i].killed) m = m | (32'd1 << mq[i].wa);
    return m;
  endfunction

  task automatic cycle(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    bit     exp_ready;
    bit     writes;
    entry_t e;
    pipe_wen   = pw;
    pipe_wa    = pa;
    pipe_wd    = pd;
    late_valid = lv;
    late_wa    = la;
    late_wd    = ld;
    #1;
    exp_ready = m_ready && (mq.size() < DEPTH);
    s_ready   = late_ready;
    chk("late_ready", {31'd0, late_ready}, {31'd0, exp_ready});
    chk("busy", {31'd0, busy}, {31'd0, mq.size() != 0});
    chk("pending_mask", pending_mask, model_pending());
    @(posedge clk);
    writes = pw && (pa != 5'd0);
    if (lv && !exp_ready && m_stall < 16'hFFFF) m_stall++;
    if (writes) begin
      foreach (mq[i]) if (mq[i].wa == pa) mq[i].killed = 1;
      m_wen = 1'b1;
      m_wa  = pa;
      m_wd  = pd;
    end else if (mq.size() != 0) begin
      e     = mq.pop_front();
      m_wen = !e.killed;
      if (!e.killed) begin
        m_wa = e.wa;
        m_wd = e.wd;
      end
    end else begin
      m_wen = 1'b0;
    end
    if (lv && exp_ready && la != 5'd0) begin
      e.wa     = la;
      e.wd     = ld;
      e.killed = writes && (la == pa);
      mq.push_back(e);
    end
    m_ready = 1;
    #1;
    chk("rf_wen", {31'd0, rf_wen}, {31'd0, m_wen});
    chk("rf_wa", {27'd0, rf_wa}, {27'd0, m_wa});
    chk("rf_wd", rf_wd, m_wd);
`ifdef WB_PERF_CNT_EN
    chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
`endif
  endtask

  typedef struct {
    logic        pw;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        e_wen;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_busy;
    logic [31:0] e_pend;
  } vec_t;

  vec_t tbl [12];
  logic [4:0] fill_wa [4];

  initial begin
    int prev_stall;
    tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h11, 1'b0, 5'd5,  32'hDEADBEEF, 1'b1, 32'h80};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 5'd7,  32'h11,       1'b0, 32'h0};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'hA9, 1'b0, 5'd7,  32'h11,       1'b1, 32'h200};
    tbl[4]  = '{1'b1, 5'd9,  32'hA,        1'b0, 5'd0,  32'h0,  1'b1, 5'd9,  32'hA,        1'b1, 32'h0};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd9,  32'hA,        1'b0, 32'h0};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h44, 1'b0, 5'd9,  32'hA,        1'b1, 32'h10};
    tbl[7]  = '{1'b1, 5'd0,  32'h123,      1'b1, 5'd6,  32'h66, 1'b1, 5'd4,  32'h44,       1'b1, 32'h40};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h55, 1'b1, 5'd6,  32'h66,       1'b0, 32'h0};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h56, 1'b0, 5'd6,  32'h66,       1'b0, 32'h0};
    tbl[10] = '{1'b1, 5'd12, 32'hC,        1'b1, 5'd12, 32'hCC, 1'b1, 5'd12, 32'hC,        1'b1, 32'h0};
    tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd12, 32'hC,        1'b0, 32'h0};
    fill_wa[0] = 5'd10;
    fill_wa[1] = 5'd11;
    fill_wa[2] = 5'd13;
    fill_wa[3] = 5'd14;

    rst        = 1'b0;
    pipe_wen   = 1'b0;
    pipe_wa    = '0;
    pipe_wd    = '0;
    late_valid = 1'b0;
    late_wa    = '0;
    late_wd    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("reset rf_wa", {27'd0, rf_wa}, 32'd0);
    chk("reset rf_wd", rf_wd, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset pending", pending_mask, 32'd0);
    chk("reset late_ready", {31'd0, late_ready}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].pw, tbl[i].pa, tbl[i].pd, tbl[i].lv, tbl[i].la, tbl[i].ld);
      chk($sformatf("vec%0d rf_wen", i), {31'd0, rf_wen}, {31'd0, tbl[i].e_wen});
      chk($sformatf("vec%0d rf_wa", i), {27'd0, rf_wa}, {27'd0, tbl[i].e_wa});
      chk($sformatf("vec%0d rf_wd", i), rf_wd, tbl[i].e_wd);
      chk($sformatf("vec%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
      chk($sformatf("vec%0d pending", i), pending_mask, tbl[i].e_pend);
    end

    // Fill the FIFO behind continuous pipe writes, then see the stalled fifth offer.
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 5'd3, 32'h300 + k, 1'b1, fill_wa[k], 32'h1000 + k);
    end
    chk("full busy", {31'd0, busy}, 32'd1);
`ifdef WB_PERF_CNT_EN
    prev_stall = stall_cnt;
`else
    prev_stall = 0;
`endif
    cycle(1'b1, 5'd3, 32'h304, 1'b1, 5'd15, 32'h1004);
    chk("full late_ready", {31'd0, s_ready}, 32'd0);
`ifdef WB_PERF_CNT_EN
    chk("stall increment", {16'd0, stall_cnt}, prev_stall + 1);
`endif
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      chk($sformatf("drain%0d wen", k), {31'd0, rf_wen}, 32'd1);
      chk($sformatf("drain%0d wa", k), {27'd0, rf_wa}, {27'd0, fill_wa[k]});
      chk($sformatf("drain%0d wd", k), rf_wd, 32'h1000 + k);
    end

    // Reset with three queued entries discards them.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 5'd3, 32'h400 + k, 1'b1, fill_wa[k], 32'h2000 + k);
    end
    pipe_wen   = 1'b0;
    late_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst pending", pending_mask, 32'd0);
    chk("midrst late_ready", {31'd0, late_ready}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      chk($sformatf("postrst%0d wen", k), {31'd0, rf_wen}, 32'd0);
    end

    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter: DEPTH, 4, late-result FIFO entries (power of 2, 2..16).
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: pipe_wen  in  1  in-order pipeline writeback request.
REQ-005 SHALL have port: pipe_wa  in  5  pipeline destination register.
REQ-006 SHALL have port: pipe_wd  in  32  pipeline result.
REQ-007 SHALL have port: late_valid  in  1  late result (load/mul/div) offered.
REQ-008 SHALL have port: late_wa  in  5  late destination register.
REQ-009 SHALL have port: late_wd  in  32  late result.
REQ-010 SHALL have port: late_ready  out  1  late result accepted this cycle when high with late_valid.
REQ-011 SHALL have port: rf_wen  out  1  register-file write enable (registered).
REQ-012 SHALL have port: rf_wa  out  5  register-file write address (registered).
REQ-013 SHALL have port: rf_wd  out  32  register-file write data (registered).
REQ-014 SHALL have port: pending_mask  out  32  bit r high = live FIFO entry targets r.
REQ-015 SHALL have port: busy  out  1  FIFO non-empty.

Function
REQ-016 SHALL accept pipe writes unconditionally; no backpressure on pipe path.
REQ-017 SHALL drive rf_* one cycle after a pipe write with pipe_wen=1, pipe_wa!=0 (latency 1, highest priority).
REQ-018 SHALL ignore pipe_wen with pipe_wa=0: rf_wen not asserted for it, slot available to FIFO.
REQ-019 SHALL set late_ready = not full; a handshake is late_valid & late_ready; no push-through-pop when full.
REQ-020 SHALL accept-and-discard late results with late_wa=0 (handshake completes, nothing enqueued).
REQ-021 SHALL enqueue a late result at edge N and make it poppable from edge N+1; minimum late latency 2 cycles to rf_wen.
REQ-022 SHALL pop the FIFO head only in cycles with no qualifying pipe write; live head drives rf_* with rf_wen=1.
REQ-023 SHALL drain FIFO entries in strict acceptance order; pipe priority may delay FIFO indefinitely.
REQ-024 SHALL mark killed every live FIFO entry whose address equals a qualifying pipe_wa (pipe result supersedes older late result).
REQ-025 SHALL also kill a late result accepted in the same cycle as a qualifying pipe write to the same address.
REQ-026 SHALL pop a killed head in any pipe-free cycle with rf_wen=0 (entry consumed, no write).
REQ-027 SHALL drive rf_wen=0 (rf_wa, rf_wd hold) in cycles with no pipe write and empty FIFO.
REQ-028 SHALL compute pending_mask and busy combinationally from registered FIFO state; killed entries excluded from pending_mask, included in busy.
REQ-029 SHALL wrap read/write pointers modulo DEPTH with an extra bit distinguishing full from empty.

Reset
REQ-030 SHALL on rst low asynchronously clear: rf_wen=0, rf_wa=0, rf_wd=0, FIFO empty, all kill flags, pending_mask=0, busy=0.
REQ-031 SHALL hold late_ready=0 while rst low; late_ready=1 from first edge after release.
REQ-032 SHALL discard all FIFO contents on reset asserted mid-operation; no partial write issued.

Configuration
REQ-033 SHALL, with WB_PERF_CNT_EN defined, add output stall_cnt (16 bits) counting cycles with late_valid & !late_ready, saturating at 16'hFFFF, reset to 0.
REQ-034 SHALL, without WB_PERF_CNT_EN, omit stall_cnt port and counter logic; all other behaviour identical.

Verification
REQ-035 SHALL cover: pipe_wen=1, wa=5, wd=32'hDEADBEEF -> next cycle rf_wen=1, rf_wa=5, rf_wd=32'hDEADBEEF.
REQ-036 SHALL cover: late wa=7 wd=32'h11 accepted at cycle 0, no pipe traffic -> rf_wen=1 wa=7 wd=32'h11 after edge 2; pending_mask bit 7 high for cycle 1 only.
REQ-037 SHALL cover: 4 late results, pipe_wen held 1 (wa=3) -> late_ready=0 on 5th offer, stall_cnt increments (macro on); pipe released -> 4 writes in order, one per cycle.
REQ-038 SHALL cover: late wa=9 enqueued, then pipe wa=9 wd=32'hA -> rf write 32'hA only; killed entry popped with rf_wen=0; pending_mask bit 9 clears.
REQ-039 SHALL cover: pipe_wa=0 with FIFO non-empty -> FIFO head written that cycle; late_wa=0 offered -> accepted, busy unchanged.
REQ-040 SHALL cover: rst low with 3 entries queued -> rf_wen=0, busy=0 immediately; no queued write appears after release.
